rv32i_writeback_pipe: RTL and testbench
=======================================

Name: rv32i_writeback_pipe

Overview:
- Parametrised next-generation writeback stage of the rv32i core.
- Commits rd and next-PC under a valid/ready handshake with the memory stage.
- Waits on late load data.
- Issues a timed pipeline flush on every PC redirect.
- Traps misaligned control-flow targets, and counts retired instructions.
- Sits between the memory stage and the register file / fetch PC mux.

Parameters:
XLEN, 32, datapath and PC width
PC_RESET, 0, o_pc value after reset
C_EXT, 0, 1 = compressed support: 16-bit instructions allowed, target alignment relaxed to 2 bytes
FLUSH_CYCLES, 2, cycles (>=1) o_flush is held and o_ready is low after a redirect
CNT_W, 64, width of retire counter

Ports:
- i_clk, in, 1, clock
- i_rst, in, 1, asynchronous active-high reset
- i_valid, in, 1, memory stage presents an instruction
- o_ready, out, 1, stage can accept this cycle
- i_opcode, in, 11, one-hot: rtype, itype, load, store, branch, jal, jalr, lui, auipc, system, fence (bit order from package)
- i_funct3, in, 3, function type
- i_rd_addr, in, 5, destination register index
- i_instr_len2, in, 1, instruction is 16-bit (ignored when C_EXT=0)
- i_alu_out, in, XLEN, ALU result; bit0 = branch taken
- i_imm, in, XLEN, immediate
- i_rs1, in, XLEN, rs1 value
- i_csr_out, in, XLEN, CSR read value
- i_go_to_trap, in, 1, exception/interrupt on this instruction
- i_return_from_trap, in, 1, mret
- i_trap_address, in, XLEN, mtvec
- i_return_address, in, XLEN, mepc
- i_load_ack, in, 1, load data valid
- i_data_load, in, XLEN, load data
- o_rd, out, XLEN, writeback value
- o_rd_addr, out, 5, writeback index
- o_wr_rd, out, 1, one-cycle write strobe
- o_pc, out, XLEN, committed PC
- o_flush, out, 1, flush younger stages
- o_retire, out, 1, one-cycle retire pulse
- o_instret, out, CNT_W, retired-instruction count
- o_exc_misaligned, out, 1, one-cycle misaligned-target pulse
- o_exc_tval, out, XLEN, faulting target

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, o_pc=PC_RESET.
  - o_rd, o_rd_addr, o_wr_rd, o_flush, o_retire, o_instret, o_exc_misaligned, o_exc_tval all 0.
  - Reset mid-WAIT_LOAD or mid-FLUSH discards the held instruction.
- States: IDLE, WAIT_LOAD, FLUSH. o_ready = (state==IDLE). Accept = i_valid && o_ready.
- Holding rule: inputs are sampled only on accept; the producer holds them while o_ready=0. i_valid while busy is ignored.
- Sequential PC: seq = o_pc + (C_EXT && i_instr_len2 ? 2 : 4).
- Target: base + i_imm, where base = i_rs1 for jalr and o_pc otherwise. Jalr clears target bit0.
- Priority on accept:
  1. trap: pc_d=i_trap_address, no rd write.
  2. mret: pc_d=i_return_address, no rd write.
  3. Normal: rd selected as rtype/itype->alu_out, load->data, jal/jalr->seq, lui->imm, auipc->o_pc+imm, CSR (system, funct3!=0)->csr_out.
     - pc_d = target for jal, jalr, or branch with alu_out[0]=1; otherwise seq.
- wr enable: 0 for branch, store, fence, system with funct3==0, and whenever i_rd_addr==0. Otherwise 1.
- Misalignment: a taken target with bit1 set (C_EXT=0), or bit0 set after jalr clearing (C_EXT=1), gives:
  - o_exc_misaligned=1, o_exc_tval=target for one cycle.
  - o_pc unchanged, no rd write, no retire, no flush; state stays IDLE.
  - The trap controller then raises i_go_to_trap on a later instruction.
- Load: accept with load && !i_load_ack -> WAIT_LOAD, holding rd_addr, seq, and wr enable. Commit occurs on the edge where i_load_ack=1. If the ack is already present on the accept cycle, commit immediately. i_load_ack outside a pending load is ignored.
- Commit (registered; outputs are valid the cycle after the commit edge):
  - o_rd, o_rd_addr, o_wr_rd pulse.
  - o_pc=pc_d.
  - o_retire pulses and o_instret increments (wrapping at 2^CNT_W) for non-trap commits; traps do not retire.
- Redirect: when pc_d != seq (trap, mret, taken branch/jump), o_flush=1 from the cycle after commit for exactly FLUSH_CYCLES cycles. State=FLUSH, with a down-counter of width clog2(FLUSH_CYCLES+1), then IDLE.
- A pending WAIT_LOAD never redirects.

Decomposition:
- Package rv32i_pkg:
  - Opcode one-hot bit indices OPC_RTYPE..OPC_FENCE.
  - State encoding localparams ST_IDLE/ST_WAIT_LOAD/ST_FLUSH.
  - FUNCT3_PRIV=3'b000.
- Sub-module rv32i_wb_nextpc (combinational) produces seq, target, taken, misaligned, and redirect. It shares one adder for target and auipc.

Test Plan:
- Reset, then i_rst pulsed high mid-operation -> o_pc=PC_RESET immediately (async), o_instret=0, o_ready=1 next cycle.
- addi x5 (itype, rd=5, alu_out=7) at o_pc=0x100 -> next cycle o_wr_rd=1, o_rd=7, o_rd_addr=5, o_pc=0x104, o_retire=1, o_flush=0.
- Load rd=3 at pc 0x200 with i_load_ack after 3 cycles, data 0xDEAD -> o_ready low 3 cycles, then o_rd=0xDEAD, o_pc=0x204.
- jal rd=1, imm=0x40 at 0x300 -> o_rd=0x304, o_pc=0x340, o_flush high exactly FLUSH_CYCLES=2 cycles, o_ready low during them.
- jalr with rs1=0x1001, imm=2 (C_EXT=0) -> target 0x1002 is misaligned -> o_exc_misaligned=1, o_exc_tval=0x1002, o_pc unchanged, no retire, no write.
- i_go_to_trap together with i_return_from_trap, mtvec=0x80 -> o_pc=0x80, o_wr_rd=0, o_instret unchanged, flush asserted.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i writeback stage: opcode one-hot
// bit positions, writeback FSM state encoding and funct3 constants.
package rv32i_pkg;

    // One-hot opcode bit positions as driven on i_opcode
    localparam int unsigned OPC_RTYPE  = 0;
    localparam int unsigned OPC_ITYPE  = 1;
    localparam int unsigned OPC_LOAD   = 2;
    localparam int unsigned OPC_STORE  = 3;
    localparam int unsigned OPC_BRANCH = 4;
    localparam int unsigned OPC_JAL    = 5;
    localparam int unsigned OPC_JALR   = 6;
    localparam int unsigned OPC_LUI    = 7;
    localparam int unsigned OPC_AUIPC  = 8;
    localparam int unsigned OPC_SYSTEM = 9;
    localparam int unsigned OPC_FENCE  = 10;
    localparam int unsigned OPC_W      = 11;

    // funct3 of ecall/ebreak/mret; any other SYSTEM funct3 is a CSR access
    localparam logic [2:0] FUNCT3_PRIV = 3'b000;

    // Writeback stage states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOAD = 2'd1,
        ST_FLUSH     = 2'd2
    } wb_state_t;

endpackage

// File: rtl/rv32i_wb_nextpc.sv
// Combinational next-PC logic for the writeback stage: sequential PC,
// control-flow target, taken/misaligned detection and redirect flag.
// A single adder computes base+imm for both jump targets and auipc.
module rv32i_wb_nextpc
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned C_EXT = 0
) (
    input  logic [XLEN-1:0]  i_pc,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_instr_len2,
    input  logic             i_branch_taken,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic             i_go_to_trap,
    input  logic             i_return_from_trap,
    input  logic [XLEN-1:0]  i_trap_address,
    input  logic [XLEN-1:0]  i_return_address,
    output logic [XLEN-1:0]  o_seq,
    output logic [XLEN-1:0]  o_sum,
    output logic [XLEN-1:0]  o_target,
    output logic             o_taken,
    output logic             o_misaligned,
    output logic [XLEN-1:0]  o_pc_next,
    output logic             o_redirect
);

    logic [XLEN-1:0] w_incr;
    logic [XLEN-1:0] w_base;
    logic            w_align_bad;

    // Sequential PC, shared target/auipc adder and target selection
    always_comb begin
        w_incr   = ((C_EXT != 0) && i_instr_len2) ? XLEN'(2) : XLEN'(4);
        o_seq    = i_pc + w_incr;
        w_base   = i_opcode[OPC_JALR] ? i_rs1 : i_pc;
        o_sum    = w_base + i_imm;
        o_target = o_sum;
        if (i_opcode[OPC_JALR]) begin
            o_target[0] = 1'b0;
        end
        o_taken  = i_opcode[OPC_JAL] | i_opcode[OPC_JALR] |
                   (i_opcode[OPC_BRANCH] & i_branch_taken);
    end

    // Misalignment only matters when no trap/mret overrides the target
    always_comb begin
        w_align_bad  = (C_EXT != 0) ? o_target[0] : o_target[1];
        o_misaligned = o_taken & w_align_bad & ~i_go_to_trap & ~i_return_from_trap;
    end

    // Final committed PC by priority: trap, mret, taken target, sequential
    always_comb begin
        if (i_go_to_trap) begin
            o_pc_next = i_trap_address;
        end else if (i_return_from_trap) begin
            o_pc_next = i_return_address;
        end else if (o_taken) begin
            o_pc_next = o_target;
        end else begin
            o_pc_next = o_seq;
        end
        o_redirect = (o_pc_next != o_seq);
    end

endmodule

// File: rtl/rv32i_writeback_pipe.sv
// rv32i writeback stage: commits rd and next PC under a valid/ready
// handshake, stalls on late load data, flushes younger stages for a
// fixed number of cycles after a redirect, traps misaligned targets
// and counts retired instructions.
module rv32i_writeback_pipe
    import rv32i_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] PC_RESET     = '0,
    parameter int unsigned     C_EXT        = 0,
    parameter int unsigned     FLUSH_CYCLES = 2,
    parameter int unsigned     CNT_W        = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic [2:0]        i_funct3,
    input  logic [4:0]        i_rd_addr,
    input  logic              i_instr_len2,
    input  logic [XLEN-1:0]   i_alu_out,
    input  logic [XLEN-1:0]   i_imm,
    input  logic [XLEN-1:0]   i_rs1,
    input  logic [XLEN-1:0]   i_csr_out,
    input  logic              i_go_to_trap,
    input  logic              i_return_from_trap,
    input  logic [XLEN-1:0]   i_trap_address,
    input  logic [XLEN-1:0]   i_return_address,
    input  logic              i_load_ack,
    input  logic [XLEN-1:0]   i_data_load,
    output logic [XLEN-1:0]   o_rd,
    output logic [4:0]        o_rd_addr,
    output logic              o_wr_rd,
    output logic [XLEN-1:0]   o_pc,
    output logic              o_flush,
    output logic              o_retire,
    output logic [CNT_W-1:0]  o_instret,
    output logic              o_exc_misaligned,
    output logic [XLEN-1:0]   o_exc_tval
);

    localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

    wb_state_t        r_state;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rd;
    logic [4:0]       r_rd_addr;
    logic             r_wr_rd;
    logic             r_flush;
    logic             r_retire;
    logic [CNT_W-1:0] r_instret;
    logic             r_exc_mis;
    logic [XLEN-1:0]  r_exc_tval;
    logic [CW-1:0]    r_cnt;
    logic [4:0]       r_hold_rd_addr;
    logic [XLEN-1:0]  r_hold_seq;
    logic             r_hold_we;

    logic [XLEN-1:0]  w_seq;
    logic [XLEN-1:0]  w_sum;
    logic [XLEN-1:0]  w_target;
    logic             w_taken;
    logic             w_misaligned;
    logic [XLEN-1:0]  w_pc_next;
    logic             w_redirect;
    logic [XLEN-1:0]  w_rd_val;
    logic             w_we;
    logic             w_accept;

    rv32i_wb_nextpc #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_nextpc (
        .i_pc               (r_pc),
        .i_opcode           (i_opcode),
        .i_instr_len2       (i_instr_len2),
        .i_branch_taken     (i_alu_out[0]),
        .i_imm              (i_imm),
        .i_rs1              (i_rs1),
        .i_go_to_trap       (i_go_to_trap),
        .i_return_from_trap (i_return_from_trap),
        .i_trap_address     (i_trap_address),
        .i_return_address   (i_return_address),
        .o_seq              (w_seq),
        .o_sum              (w_sum),
        .o_target           (w_target),
        .o_taken            (w_taken),
        .o_misaligned       (w_misaligned),
        .o_pc_next          (w_pc_next),
        .o_redirect         (w_redirect)
    );

    // Writeback value select and write-enable decode
    always_comb begin
        w_rd_val = '0;
        if (i_opcode[OPC_RTYPE] || i_opcode[OPC_ITYPE]) begin
            w_rd_val = i_alu_out;
        end else if (i_opcode[OPC_LOAD]) begin
            w_rd_val = i_data_load;
        end else if (i_opcode[OPC_JAL] || i_opcode[OPC_JALR]) begin
            w_rd_val = w_seq;
        end else if (i_opcode[OPC_LUI]) begin
            w_rd_val = i_imm;
        end else if (i_opcode[OPC_AUIPC]) begin
            w_rd_val = w_sum;
        end else if (i_opcode[OPC_SYSTEM] && (i_funct3 != FUNCT3_PRIV)) begin
            w_rd_val = i_csr_out;
        end
        w_we = ~(i_opcode[OPC_BRANCH] | i_opcode[OPC_STORE] | i_opcode[OPC_FENCE] |
                 (i_opcode[OPC_SYSTEM] & (i_funct3 == FUNCT3_PRIV))) &
               (i_rd_addr != 5'd0);
    end

    // Handshake: only IDLE accepts a new instruction
    always_comb begin
        o_ready  = (r_state == ST_IDLE);
        w_accept = i_valid & o_ready;
    end

    // Writeback FSM with registered commit, flush and exception outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_pc           <= PC_RESET;
            r_rd           <= '0;
            r_rd_addr      <= '0;
            r_wr_rd        <= 1'b0;
            r_flush        <= 1'b0;
            r_retire       <= 1'b0;
            r_instret      <= '0;
            r_exc_mis      <= 1'b0;
            r_exc_tval     <= '0;
            r_cnt          <= '0;
            r_hold_rd_addr <= '0;
            r_hold_seq     <= '0;
            r_hold_we      <= 1'b0;
        end else begin
            r_wr_rd    <= 1'b0;
            r_retire   <= 1'b0;
            r_exc_mis  <= 1'b0;
            r_exc_tval <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (i_go_to_trap) begin
                            r_pc <= w_pc_next;
                            if (w_redirect) begin
                                r_state <= ST_FLUSH;
                                r_flush <= 1'b1;
                                r_cnt   <= CW'(FLUSH_CYCLES);
                            end
                        end else if (i_return_from_trap) begin
                            r_pc      <= w_pc_next;
                            r_retire  <= 1'b1;
                            r_instret <= r_instret + CNT_W'(1);
                            if (w_redirect) begin
                                r_state <= ST_FLUSH;
                                r_flush <= 1'b1;
                                r_cnt   <= CW'(FLUSH_CYCLES);
                            end
                        end else if (w_misaligned) begin
                            r_exc_mis  <= 1'b1;
                            r_exc_tval <= w_target;
                        end else if (i_opcode[OPC_LOAD] && !i_load_ack) begin
                            r_state        <= ST_WAIT_LOAD;
                            r_hold_rd_addr <= i_rd_addr;
                            r_hold_seq     <= w_seq;
                            r_hold_we      <= w_we;
                        end else begin
                            r_rd      <= w_rd_val;
                            r_rd_addr <= i_rd_addr;
                            r_wr_rd   <= w_we;
                            r_pc      <= w_pc_next;
                            r_retire  <= 1'b1;
                            r_instret <= r_instret + CNT_W'(1);
                            if (w_redirect) begin
                                r_state <= ST_FLUSH;
                                r_flush <= 1'b1;
                                r_cnt   <= CW'(FLUSH_CYCLES);
                            end
                        end
                    end
                end
                ST_WAIT_LOAD: begin
                    if (i_load_ack) begin
                        r_rd      <= i_data_load;
                        r_rd_addr <= r_hold_rd_addr;
                        r_wr_rd   <= r_hold_we;
                        r_pc      <= r_hold_seq;
                        r_retire  <= 1'b1;
                        r_instret <= r_instret + CNT_W'(1);
                        r_state   <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_IDLE;
                        r_flush <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd             = r_rd;
    assign o_rd_addr        = r_rd_addr;
    assign o_wr_rd          = r_wr_rd;
    assign o_pc             = r_pc;
    assign o_flush          = r_flush;
    assign o_retire         = r_retire;
    assign o_instret        = r_instret;
    assign o_exc_misaligned = r_exc_mis;
    assign o_exc_tval       = r_exc_tval;

endmodule

// File: tb/tb_rv32i_writeback_pipe.sv
// Directed testbench for rv32i_writeback_pipe (XLEN=32, C_EXT=0, FLUSH_CYCLES=2).
module tb_rv32i_writeback_pipe;
    import rv32i_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [10:0] i_opcode;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd_addr;
    logic        i_instr_len2;
    logic [31:0] i_alu_out, i_imm, i_rs1, i_csr_out;
    logic        i_go_to_trap, i_return_from_trap;
    logic [31:0] i_trap_address, i_return_address;
    logic        i_load_ack;
    logic [31:0] i_data_load;
    logic [31:0] o_rd;
    logic [4:0]  o_rd_addr;
    logic        o_wr_rd;
    logic [31:0] o_pc;
    logic        o_flush, o_retire;
    logic [63:0] o_instret;
    logic        o_exc_misaligned;
    logic [31:0] o_exc_tval;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_instret;

    rv32i_writeback_pipe #(
        .XLEN(32), .PC_RESET(32'h0), .C_EXT(0), .FLUSH_CYCLES(2), .CNT_W(64)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_rd_addr(i_rd_addr),
        .i_instr_len2(i_instr_len2), .i_alu_out(i_alu_out), .i_imm(i_imm),
        .i_rs1(i_rs1), .i_csr_out(i_csr_out), .i_go_to_trap(i_go_to_trap),
        .i_return_from_trap(i_return_from_trap), .i_trap_address(i_trap_address),
        .i_return_address(i_return_address), .i_load_ack(i_load_ack),
        .i_data_load(i_data_load), .o_rd(o_rd), .o_rd_addr(o_rd_addr),
        .o_wr_rd(o_wr_rd), .o_pc(o_pc), .o_flush(o_flush), .o_retire(o_retire),
        .o_instret(o_instret), .o_exc_misaligned(o_exc_misaligned),
        .o_exc_tval(o_exc_tval)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] opc(input int unsigned idx);
        logic [10:0] one;
        one = 11'd1;
        return one << idx;
    endfunction

    task automatic clr();
        i_valid = 0; i_opcode = '0; i_funct3 = '0; i_rd_addr = '0; i_instr_len2 = 0;
        i_alu_out = '0; i_imm = '0; i_rs1 = '0; i_csr_out = '0; i_go_to_trap = 0;
        i_return_from_trap = 0; i_trap_address = '0; i_return_address = '0;
        i_load_ack = 0; i_data_load = '0;
    endtask

    // Present the current input fields for one accept edge; returns at edge+1
    task automatic fire();
        @(negedge i_clk);
        i_valid = 1;
        @(posedge i_clk);
        #1;
        i_valid = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && !o_ready; i++) begin
            @(posedge i_clk);
            #1;
        end
        if (!o_ready) begin
            checks++; errors++;
            $display("FAIL wait_idle_timeout: o_ready=%b expected 1", o_ready);
        end
    endtask

    // Move the committed PC with a non-retiring trap
    task automatic set_pc(input logic [31:0] addr);
        clr();
        i_go_to_trap = 1;
        i_trap_address = addr;
        fire();
        clr();
        wait_idle();
    endtask

    task automatic test_reset();
        clr();
        i_rst = 1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", o_pc, 32'h0); end
        checks++; if (o_instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", o_instret); end
        checks++; if ({o_wr_rd, o_flush, o_retire, o_exc_misaligned} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {o_wr_rd, o_flush, o_retire, o_exc_misaligned}); end
        checks++; if (o_rd !== 32'h0 || o_rd_addr !== 5'd0 || o_exc_tval !== 32'h0) begin errors++; $display("FAIL reset_data: rd=%h addr=%0d tval=%h expected 0", o_rd, o_rd_addr, o_exc_tval); end
        @(negedge i_clk);
        i_rst = 0;
        @(posedge i_clk);
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        exp_instret = 0;
    endtask

    task automatic test_addi();
        set_pc(32'h100);
        i_opcode = opc(OPC_ITYPE); i_rd_addr = 5; i_alu_out = 7;
        fire();
        exp_instret++;
        checks++; if (o_wr_rd !== 1'b1 || o_rd !== 32'd7 || o_rd_addr !== 5'd5) begin errors++; $display("FAIL addi_wb: wr=%b rd=%h addr=%0d expected 1/7/5", o_wr_rd, o_rd, o_rd_addr); end
        checks++; if (o_pc !== 32'h104) begin errors++; $display("FAIL addi_pc: got %h expected %h", o_pc, 32'h104); end
        checks++; if (o_retire !== 1'b1 || o_flush !== 1'b0) begin errors++; $display("FAIL addi_retire_flush: retire=%b flush=%b expected 1/0", o_retire, o_flush); end
        checks++; if (o_instret !== exp_instret) begin errors++; $display("FAIL addi_instret: got %0d expected %0d", o_instret, exp_instret); end
        @(posedge i_clk);
        #1;
        checks++; if (o_wr_rd !== 1'b0 || o_retire !== 1'b0) begin errors++; $display("FAIL addi_pulse_width: wr=%b retire=%b expected 0/0", o_wr_rd, o_retire); end
        clr();
    endtask

    task automatic test_load();
        set_pc(32'h200);
        i_opcode = opc(OPC_LOAD); i_rd_addr = 3;
        fire();
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_ready !== 1'b0 || o_wr_rd !== 1'b0) begin errors++; $display("FAIL load_wait_%0d: ready=%b wr=%b expected 0/0", k, o_ready, o_wr_rd); end
            @(negedge i_clk);
            if (k == 2) begin i_load_ack = 1; i_data_load = 32'hDEAD; end
            @(posedge i_clk);
            #1;
        end
        exp_instret++;
        checks++; if (o_wr_rd !== 1'b1 || o_rd !== 32'hDEAD || o_rd_addr !== 5'd3) begin errors++; $display("FAIL load_commit: wr=%b rd=%h addr=%0d expected 1/dead/3", o_wr_rd, o_rd, o_rd_addr); end
        checks++; if (o_pc !== 32'h204 || o_ready !== 1'b1) begin errors++; $display("FAIL load_pc_ready: pc=%h ready=%b expected 204/1", o_pc, o_ready); end
        // Ack already present on the accept cycle commits immediately
        i_rd_addr = 4; i_data_load = 32'h55;
        fire();
        exp_instret++;
        checks++; if (o_wr_rd !== 1'b1 || o_rd !== 32'h55 || o_pc !== 32'h208) begin errors++; $display("FAIL load_fast: wr=%b rd=%h pc=%h expected 1/55/208", o_wr_rd, o_rd, o_pc); end
        // Stray ack with nothing pending is ignored
        @(posedge i_clk);
        #1;
        checks++; if (o_wr_rd !== 1'b0 || o_pc !== 32'h208 || o_instret !== exp_instret) begin errors++; $display("FAIL load_stray_ack: wr=%b pc=%h instret=%0d expected 0/208/%0d", o_wr_rd, o_pc, o_instret, exp_instret); end
        clr();
    endtask

    task automatic test_jal();
        set_pc(32'h300);
        i_opcode = opc(OPC_JAL); i_rd_addr = 1; i_imm = 32'h40;
        fire();
        exp_instret++;
        checks++; if (o_rd !== 32'h304 || o_wr_rd !== 1'b1) begin errors++; $display("FAIL jal_link: rd=%h wr=%b expected 304/1", o_rd, o_wr_rd); end
        checks++; if (o_pc !== 32'h340) begin errors++; $display("FAIL jal_pc: got %h expected %h", o_pc, 32'h340); end
        checks++; if (o_flush !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL jal_flush_c1: flush=%b ready=%b expected 1/0", o_flush, o_ready); end
        clr();
        @(posedge i_clk);
        #1;
        checks++; if (o_flush !== 1'b1 || o_ready !== 1'b0) begin errors++; $display("FAIL jal_flush_c2: flush=%b ready=%b expected 1/0", o_flush, o_ready); end
        @(posedge i_clk);
        #1;
        checks++; if (o_flush !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL jal_flush_end: flush=%b ready=%b expected 0/1", o_flush, o_ready); end
        checks++; if (o_instret !== exp_instret) begin errors++; $display("FAIL jal_instret: got %0d expected %0d", o_instret, exp_instret); end
    endtask

    task automatic test_misaligned();
        set_pc(32'h400);
        i_opcode = opc(OPC_JALR); i_rd_addr = 1; i_rs1 = 32'h1001; i_imm = 32'h2;
        fire();
        checks++; if (o_exc_misaligned !== 1'b1 || o_exc_tval !== 32'h1002) begin errors++; $display("FAIL mis_exc: exc=%b tval=%h expected 1/1002", o_exc_misaligned, o_exc_tval); end
        checks++; if (o_pc !== 32'h400 || o_wr_rd !== 1'b0 || o_retire !== 1'b0) begin errors++; $display("FAIL mis_nocommit: pc=%h wr=%b retire=%b expected 400/0/0", o_pc, o_wr_rd, o_retire); end
        checks++; if (o_flush !== 1'b0 || o_ready !== 1'b1 || o_instret !== exp_instret) begin errors++; $display("FAIL mis_state: flush=%b ready=%b instret=%0d expected 0/1/%0d", o_flush, o_ready, o_instret, exp_instret); end
        clr();
        @(posedge i_clk);
        #1;
        checks++; if (o_exc_misaligned !== 1'b0) begin errors++; $display("FAIL mis_pulse_width: got %b expected 0", o_exc_misaligned); end
    endtask

    task automatic test_trap();
        set_pc(32'h500);
        i_opcode = opc(OPC_ITYPE); i_rd_addr = 7; i_alu_out = 32'h99;
        i_go_to_trap = 1; i_return_from_trap = 1;
        i_trap_address = 32'h80; i_return_address = 32'h900;
        fire();
        checks++; if (o_pc !== 32'h80) begin errors++; $display("FAIL trap_pc: got %h expected %h", o_pc, 32'h80); end
        checks++; if (o_wr_rd !== 1'b0 || o_retire !== 1'b0 || o_instret !== exp_instret) begin errors++; $display("FAIL trap_noretire: wr=%b retire=%b instret=%0d expected 0/0/%0d", o_wr_rd, o_retire, o_instret, exp_instret); end
        checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL trap_flush: got %b expected 1", o_flush); end
        clr();
        wait_idle();
    endtask

    // PC is 0x80 on entry
    task automatic test_back_to_back();
        i_opcode = opc(OPC_BRANCH); i_rd_addr = 9; i_imm = 32'h20; i_alu_out = 0;
        fire();
        exp_instret++;
        checks++; if (o_pc !== 32'h84 || o_wr_rd !== 1'b0 || o_flush !== 1'b0 || o_retire !== 1'b1) begin errors++; $display("FAIL br_nt: pc=%h wr=%b flush=%b retire=%b expected 84/0/0/1", o_pc, o_wr_rd, o_flush, o_retire); end
        i_alu_out = 1;
        fire();
        exp_instret++;
        checks++; if (o_pc !== 32'hA4 || o_flush !== 1'b1 || o_wr_rd !== 1'b0) begin errors++; $display("FAIL br_taken: pc=%h flush=%b wr=%b expected a4/1/0", o_pc, o_flush, o_wr_rd); end
        clr();
        wait_idle();
        i_opcode = opc(OPC_LUI); i_rd_addr = 2; i_imm = 32'h12345000;
        fire();
        exp_instret++;
        checks++; if (o_rd !== 32'h12345000 || o_pc !== 32'hA8 || o_wr_rd !== 1'b1) begin errors++; $display("FAIL lui: rd=%h pc=%h wr=%b expected 12345000/a8/1", o_rd, o_pc, o_wr_rd); end
        i_opcode = opc(OPC_AUIPC); i_imm = 32'h1000;
        fire();
        exp_instret++;
        checks++; if (o_rd !== 32'h10A8 || o_pc !== 32'hAC) begin errors++; $display("FAIL auipc: rd=%h pc=%h expected 10a8/ac", o_rd, o_pc); end
        i_opcode = opc(OPC_SYSTEM); i_funct3 = 3'd2; i_rd_addr = 6; i_csr_out = 32'hCAFE;
        fire();
        exp_instret++;
        checks++; if (o_rd !== 32'hCAFE || o_rd_addr !== 5'd6 || o_wr_rd !== 1'b1 || o_pc !== 32'hB0) begin errors++; $display("FAIL csr: rd=%h addr=%0d wr=%b pc=%h expected cafe/6/1/b0", o_rd, o_rd_addr, o_wr_rd, o_pc); end
        clr();
        i_opcode = opc(OPC_ITYPE); i_rd_addr = 0; i_alu_out = 32'h77;
        fire();
        exp_instret++;
        checks++; if (o_wr_rd !== 1'b0 || o_retire !== 1'b1 || o_pc !== 32'hB4) begin errors++; $display("FAIL rd_x0: wr=%b retire=%b pc=%h expected 0/1/b4", o_wr_rd, o_retire, o_pc); end
        i_opcode = opc(OPC_STORE); i_rd_addr = 5;
        fire();
        exp_instret++;
        checks++; if (o_wr_rd !== 1'b0 || o_pc !== 32'hB8 || o_instret !== exp_instret) begin errors++; $display("FAIL store: wr=%b pc=%h instret=%0d expected 0/b8/%0d", o_wr_rd, o_pc, o_instret, exp_instret); end
        clr();
    endtask

    task automatic test_reset_mid();
        set_pc(32'h600);
        i_opcode = opc(OPC_LOAD); i_rd_addr = 9;
        fire();
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rstmid_waiting: ready=%b expected 0", o_ready); end
        #2;
        i_rst = 1;
        #1;
        checks++; if (o_pc !== 32'h0 || o_instret !== 64'd0) begin errors++; $display("FAIL rstmid_async: pc=%h instret=%0d expected 0/0", o_pc, o_instret); end
        @(negedge i_clk);
        i_rst = 0;
        exp_instret = 0;
        @(posedge i_clk);
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", o_ready); end
        @(negedge i_clk);
        i_load_ack = 1; i_data_load = 32'hBEEF;
        @(posedge i_clk);
        #1;
        checks++; if (o_wr_rd !== 1'b0 || o_pc !== 32'h0 || o_instret !== 64'd0) begin errors++; $display("FAIL rstmid_discard: wr=%b pc=%h instret=%0d expected 0/0/0", o_wr_rd, o_pc, o_instret); end
        clr();
    endtask

    initial begin
        exp_instret = 0;
        i_rst = 1;
        clr();
        test_reset();
        test_addi();
        test_load();
        test_jal();
        test_misaligned();
        test_trap();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
